// File: rtl/spi_flash_master_if.sv
// Command, write-stream and read-stream bus of spi_flash_master.
// cmd: a command transfers on a clk edge where cmd_valid and cmd_ready are both high;
// wr: a byte transfers on a clk edge where wr_valid and wr_ready are both high;
// rd_valid and done are single-clk pulses with no back-pressure.
interface spi_flash_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_data, wr_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_data, wr_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/spi_flash_master.sv
// SPI mode-0 serial flash command engine (opcode / address / dummy / data phases).
// Optional SPI_FLASH_MASTER_POLL_BUSY_EN: poll RDSR after program/erase until WIP clears.
module spi_flash_master #(
  parameter int SCK_HALF = 2,
  parameter int CS_GAP   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_flash_master_if.slave     bus,
  output logic                  flash_c,
  output logic                  flash_d,
  output logic                  flash_s,
  output logic                  flash_w,
  output logic                  flash_hold,
  input  logic                  flash_q,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPC   = 3'd1,
    ADDR  = 3'd2,
    DUMMY = 3'd3,
    WDATA = 3'd4,
    RDATA = 3'd5,
    GAP   = 3'd6
`ifdef SPI_FLASH_MASTER_POLL_BUSY_EN
    , POLL = 3'd7
`endif
  } state_t;

  localparam logic [15:0] SCK_LAST = 16'(SCK_HALF - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

  state_t      state;
  logic [15:0] sck_cnt;
  logic [15:0] gap_cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] tx_sh;
  logic [7:0]  rx_sh;
  logic [8:0]  bytes_left;
  logic [7:0]  op_q;
  logic [23:0] addr_q;
  logic        shift_en;
  logic [4:0]  seg_last;
`ifdef SPI_FLASH_MASTER_POLL_BUSY_EN
  logic        poll_pend;
`endif

  assign flash_w    = 1'b1;
  assign flash_hold = 1'b1;
  assign dbg_state  = state;

  function automatic logic has_addr(input logic [7:0] op);
    return op inside {8'h02, 8'h03, 8'h0B, 8'hD8};
  endfunction

  // The serial clock runs only in shifting phases; WDATA pauses while waiting for a byte.
  always_comb begin
    shift_en = 1'b0;
    seg_last = 5'd7;
    case (state)
      OPC, DUMMY, RDATA: shift_en = 1'b1;
      ADDR: begin
        shift_en = 1'b1;
        seg_last = 5'd23;
      end
      WDATA: shift_en = !bus.wr_ready;
`ifdef SPI_FLASH_MASTER_POLL_BUSY_EN
      POLL: begin
        shift_en = 1'b1;
        seg_last = 5'd15;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      flash_c       <= 1'b0;
      flash_d       <= 1'b0;
      flash_s       <= 1'b1;
      bus.cmd_ready <= 1'b0;
      bus.wr_ready  <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= 8'h00;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      sck_cnt       <= '0;
      gap_cnt       <= '0;
      bit_cnt       <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      bytes_left    <= '0;
      op_q          <= '0;
      addr_q        <= '0;
`ifdef SPI_FLASH_MASTER_POLL_BUSY_EN
      poll_pend     <= 1'b0;
`endif
    end else begin
      bus.done     <= 1'b0;
      bus.rd_valid <= 1'b0;

      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            flash_s       <= 1'b0;
            flash_d       <= bus.cmd_op[7];
            tx_sh         <= {bus.cmd_op, 16'h0000};
            op_q          <= bus.cmd_op;
            addr_q        <= bus.cmd_addr;
            // A page program never wraps: anything past one page is dropped.
            bytes_left    <= (bus.cmd_op == 8'h02 && bus.cmd_len > 9'd256) ? 9'd256 : bus.cmd_len;
            sck_cnt       <= '0;
            bit_cnt       <= '0;
            state         <= OPC;
`ifdef SPI_FLASH_MASTER_POLL_BUSY_EN
            poll_pend     <= bus.cmd_op inside {8'h01, 8'h02, 8'hD8, 8'hC7};
`endif
          end
        end
        WDATA: begin
          if (bus.wr_ready && bus.wr_valid) begin
            tx_sh        <= {bus.wr_data, 16'h0000};
            flash_d      <= bus.wr_data[7];
            bus.wr_ready <= 1'b0;
            sck_cnt      <= '0;
          end
        end
        GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 16'd1;
          end else begin
`ifdef SPI_FLASH_MASTER_POLL_BUSY_EN
            if (poll_pend) begin
              flash_s <= 1'b0;
              flash_d <= 1'b0;
              tx_sh   <= {8'h05, 16'h0000};
              sck_cnt <= '0;
              bit_cnt <= '0;
              state   <= POLL;
            end else
`endif
            begin
              bus.done      <= 1'b1;
              bus.busy      <= 1'b0;
              bus.cmd_ready <= 1'b1;
              state         <= IDLE;
            end
          end
        end
        default: ;
      endcase

      if (shift_en) begin
        if (sck_cnt != SCK_LAST) begin
          sck_cnt <= sck_cnt + 16'd1;
        end else begin
          sck_cnt <= '0;
          if (!flash_c) begin
            // Rising edge: the flash has held flash_q stable since the previous fall.
            flash_c <= 1'b1;
            rx_sh   <= {rx_sh[6:0], flash_q};
            if (state == RDATA && bit_cnt[2:0] == 3'd7) begin
              bus.rd_data  <= {rx_sh[6:0], flash_q};
              bus.rd_valid <= 1'b1;
            end
`ifdef SPI_FLASH_MASTER_POLL_BUSY_EN
            if (state == POLL && bit_cnt == 5'd15) poll_pend <= flash_q;
`endif
          end else begin
            flash_c <= 1'b0;
            flash_d <= tx_sh[22];
            tx_sh   <= {tx_sh[22:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == seg_last) begin
              bit_cnt <= '0;
              case (state)
                OPC: begin
                  if (has_addr(op_q)) begin
                    tx_sh   <= addr_q;
                    flash_d <= addr_q[23];
                    state   <= ADDR;
                  end else if (op_q == 8'h01 && bytes_left != 9'd0) begin
                    bus.wr_ready <= 1'b1;
                    state        <= WDATA;
                  end else if (op_q == 8'h05 && bytes_left != 9'd0) begin
                    state <= RDATA;
                  end else begin
                    flash_s <= 1'b1;
                    gap_cnt <= '0;
                    state   <= GAP;
                  end
                end
                ADDR: begin
                  if (op_q == 8'hD8 || bytes_left == 9'd0) begin
                    flash_s <= 1'b1;
                    gap_cnt <= '0;
                    state   <= GAP;
                  end else if (op_q == 8'h0B) begin
                    state <= DUMMY;
                  end else if (op_q == 8'h02) begin
                    bus.wr_ready <= 1'b1;
                    state        <= WDATA;
                  end else begin
                    state <= RDATA;
                  end
                end
                DUMMY: state <= RDATA;
                WDATA, RDATA: begin
                  bytes_left <= bytes_left - 9'd1;
                  if (bytes_left == 9'd1) begin
                    flash_s <= 1'b1;
                    gap_cnt <= '0;
                    state   <= GAP;
                  end else if (state == WDATA) begin
                    bus.wr_ready <= 1'b1;
                  end
                end
`ifdef SPI_FLASH_MASTER_POLL_BUSY_EN
                POLL: begin
                  flash_s <= 1'b1;
                  gap_cnt <= '0;
                  state   <= GAP;
                end
`endif
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/spi_flash_master.md
SPI_FLASH_MASTER -- requirements
Module: spi_flash_master

Interface
REQ-001 Parameter: SCK_HALF, default 2, meaning system clocks per flash_c half-period (minimum 1).
REQ-002 Parameter: CS_GAP, default 8, meaning minimum system clocks flash_s stays high between two frames (tSHSL).
REQ-003 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: cmd_valid / cmd_ready  input / output  1 / 1  command handshake; command accepted when both are high on a clk edge.
REQ-006 Port: cmd_op  input  8  flash opcode.
REQ-007 Port: cmd_addr  input  24  byte address.
REQ-008 Port: cmd_len  input  9  data byte count, 0..511.
REQ-009 Port: wr_data / wr_valid / wr_ready  input / input / output  8 / 1 / 1  write byte stream, MSB sent first.
REQ-010 Port: rd_data / rd_valid  output / output  8 / 1  read byte stream; rd_valid is a one-clk pulse.
REQ-011 Port: busy / done  output / output  1 / 1  frame in progress / one-clk pulse when the command completes.
REQ-012 Port: flash_c, flash_d, flash_s, flash_w, flash_hold  output  1 each  connect to flash pins c, data_in, s, w, hold.
REQ-013 Port: flash_q  input  1  connects to flash pin data_out.

Function
REQ-014 SHALL use SPI mode 0: flash_c idles low; flash_d changes only while flash_c is low; flash_q is sampled on the flash_c rising edge.
REQ-015 FSM states SHALL be IDLE, OPC, ADDR, DUMMY, WDATA, RDATA, GAP, POLL.
- IDLE: cmd_ready=1. Accepting a command drives flash_s low and enters OPC.
REQ-016 OPC SHALL shift 8 opcode bits.
- Then ADDR if op is 02/03/0B/D8.
- Else WDATA if op is 01 and len>0.
- Else RDATA if op is 05 and len>0.
- Else GAP.
REQ-017 ADDR SHALL shift 24 bits, MSB first.
- Then DUMMY (8 clocks, flash_d=0) for 0B.
- Then WDATA for 02.
- Then RDATA for 03/0B.
- Then GAP for D8, or for any op with len=0.
REQ-018 WDATA byte-count rule: op 02 with cmd_len>256 SHALL send exactly 256 bytes; all other cases send cmd_len bytes.
REQ-019 WDATA SHALL raise wr_ready for one clk at each byte boundary.
- If wr_valid is low at that boundary, flash_c SHALL stall low with flash_s held low until wr_valid is high.
REQ-020 RDATA SHALL pulse rd_valid one clk after the 8th sampled bit of each byte, until cmd_len bytes have been delivered.
REQ-021 GAP SHALL hold flash_s high for CS_GAP clks, then pulse done and return to IDLE.
REQ-022 flash_w and flash_hold SHALL be held at 1 constantly.
REQ-023 Opcode-only commands (06, 04, C7, AB, and all undecoded values) SHALL send 8 bits, then enter GAP.
REQ-024 cmd_valid while busy=1 SHALL be ignored (cmd_ready=0); no command queueing.

Reset
REQ-025 On rst_n low, SHALL immediately force the following, regardless of state:
- outputs: flash_c=0, flash_d=0, flash_s=1, flash_w=1, flash_hold=1, cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0;
- internal: FSM=IDLE, counters=0.
REQ-026 Reset mid-frame SHALL abort the frame without a done pulse.
REQ-027 cmd_ready SHALL rise on the first clk after rst_n deasserts.

Configuration
REQ-028 Macro SPI_FLASH_MASTER_POLL_BUSY_EN: when defined, after GAP for ops 01/02/D8/C7 the FSM SHALL enter POLL.
- POLL issues RDSR (05), reads 1 status byte, and repeats it (with CS_GAP between frames) until bit0 (WIP)=0.
- Only then SHALL done pulse; POLL status bytes SHALL NOT assert rd_valid.
REQ-029 Without the macro, POLL state and logic SHALL be absent, and done SHALL pulse at the end of GAP for all ops.

Verification
REQ-030 WREN: cmd_op=06 -> exactly 8 flash_c pulses, flash_d bits 00000110, then flash_s high ≥CS_GAP clks, then one done pulse.
REQ-031 READ: op=03, addr=0x012345, len=4, flash preloaded with AA BB CC DD -> 32 flash_c pulses carrying the command and address, then 4 rd_valid pulses with AA, BB, CC, DD.
REQ-032 PP: op=02, len=300 -> exactly 256 wr_ready pulses and 8+24+2048 flash_c pulses; with POLL_EN, done only after flash WIP clears.
REQ-033 Write starvation: wr_valid held low for 50 clks before byte 2 -> flash_c low and flash_s low throughout the stall; data resumes intact.
REQ-034 rst_n pulsed low during ADDR of a READ -> flash_s=1 within the same clk, no done or rd_valid pulse, and a subsequent READ returns correct data.
